// File: rtl/c2h_frame_buffer.sv
// c2h_frame_buffer: store-and-forward frame buffer between a no-backpressure RX
// stream and an AXI4-Stream master. Only complete frames are forwarded; a frame
// that cannot fit is dropped whole. Each frame's byte length is presented on m_len.
//
// Ports
//   user_clk, user_reset : clock, synchronous active-high reset
//   rx_valid/rx_data/rx_ben/rx_last : input beats (always consumed)
//   m_tvalid/m_tready/m_tdata/m_tkeep/m_tlast : output stream
//   m_len     : byte length of the frame on the output, held for the whole frame
//   frame_cnt : committed frames since reset (wraps)
//   drop_cnt  : dropped frames since reset (wraps)
module c2h_frame_buffer #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned DATA_DEPTH = 256,
    parameter int unsigned LEN_DEPTH  = 32,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  user_clk,
    input  logic                  user_reset,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic [KEEP_WIDTH-1:0] rx_ben,
    input  logic                  rx_last,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic [KEEP_WIDTH-1:0] m_tkeep,
    output logic                  m_tlast,
    output logic [LEN_WIDTH-1:0]  m_len,
    output logic [31:0]           frame_cnt,
    output logic [31:0]           drop_cnt
);

    localparam int unsigned DA_W  = $clog2(DATA_DEPTH);
    localparam int unsigned DP_W  = DA_W + 1;
    localparam int unsigned LA_W  = $clog2(LEN_DEPTH);
    localparam int unsigned LP_W  = LA_W + 1;
    localparam int unsigned BC_W  = $clog2(KEEP_WIDTH + 1);
    localparam int unsigned SUM_W = LEN_WIDTH + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_WIDTH-1:0] ben;
        logic                  last;
    } entry_t;

    typedef enum logic [1:0] {IN_IDLE, IN_ACCEPT, IN_DROP}   in_state_t;
    typedef enum logic [1:0] {OUT_IDLE, OUT_LOAD, OUT_SEND} out_state_t;

    entry_t               data_mem [DATA_DEPTH];
    logic [LEN_WIDTH-1:0] len_mem  [LEN_DEPTH];

    in_state_t            in_state, in_next;
    out_state_t           out_state, out_next;

    logic [DP_W-1:0]      wr_ptr, commit_ptr, rd_ptr;
    logic [LP_W-1:0]      len_wr_ptr, len_rd_ptr;
    logic [LEN_WIDTH-1:0] byte_acc, acc_base, acc_next;
    logic [SUM_W-1:0]     acc_sum;
    logic [BC_W-1:0]      beat_bytes;
    logic                 len_push_pend;
    logic [LEN_WIDTH-1:0] len_push_val;

    logic data_full, len_full, len_empty;
    logic wr_en, acc_start, commit, rollback, drop_inc;
    logic len_pop, out_load, out_reload, beat_adv;
    logic [DA_W-1:0] rd_addr;
    entry_t          rd_entry;

    function automatic logic [BC_W-1:0] popcount(input logic [KEEP_WIDTH-1:0] v);
        logic [BC_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(KEEP_WIDTH); i++) begin
            n = n + BC_W'(v[i]);
        end
        return n;
    endfunction

    // Fullness from pre-edge pointers. A length commit is written one cycle after
    // the frame's last beat, so a pending push counts as an occupied slot.
    always_comb begin
        data_full = (wr_ptr[DA_W] != rd_ptr[DA_W]) &&
                    (wr_ptr[DA_W-1:0] == rd_ptr[DA_W-1:0]);
        len_empty = (len_wr_ptr == len_rd_ptr);
        len_full  = ((len_wr_ptr[LA_W] != len_rd_ptr[LA_W]) &&
                     (len_wr_ptr[LA_W-1:0] == len_rd_ptr[LA_W-1:0])) ||
                    (len_push_pend && ((len_wr_ptr - len_rd_ptr) == LP_W'(LEN_DEPTH - 1)));
    end

    // Saturating frame byte accumulator
    always_comb begin
        beat_bytes = popcount(rx_ben);
        acc_base   = acc_start ? '0 : byte_acc;
        acc_sum    = SUM_W'(acc_base) + SUM_W'(beat_bytes);
        acc_next   = acc_sum[LEN_WIDTH] ? '1 : acc_sum[LEN_WIDTH-1:0];
    end

    // Input FSM: state register
    always_ff @(posedge user_clk) begin
        if (user_reset) in_state <= IN_IDLE;
        else            in_state <= in_next;
    end

    // Input FSM: next state and write/commit/drop strobes
    always_comb begin
        in_next   = in_state;
        wr_en     = 1'b0;
        acc_start = 1'b0;
        commit    = 1'b0;
        rollback  = 1'b0;
        drop_inc  = 1'b0;
        case (in_state)
            IN_IDLE: begin
                if (rx_valid) begin
                    if (len_full || data_full) begin
                        if (rx_last) drop_inc = 1'b1;
                        else         in_next  = IN_DROP;
                    end else begin
                        wr_en     = 1'b1;
                        acc_start = 1'b1;
                        if (rx_last) commit  = 1'b1;
                        else         in_next = IN_ACCEPT;
                    end
                end
            end
            IN_ACCEPT: begin
                if (rx_valid) begin
                    if (data_full) begin
                        rollback = 1'b1;
                        if (rx_last) begin
                            drop_inc = 1'b1;
                            in_next  = IN_IDLE;
                        end else begin
                            in_next  = IN_DROP;
                        end
                    end else begin
                        wr_en = 1'b1;
                        if (rx_last) begin
                            commit  = 1'b1;
                            in_next = IN_IDLE;
                        end
                    end
                end
            end
            IN_DROP: begin
                if (rx_valid && rx_last) begin
                    drop_inc = 1'b1;
                    in_next  = IN_IDLE;
                end
            end
            default: in_next = IN_IDLE;
        endcase
    end

    // Write side pointers, length hand-off and counters
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            wr_ptr        <= '0;
            commit_ptr    <= '0;
            byte_acc      <= '0;
            len_push_pend <= 1'b0;
            len_push_val  <= '0;
            len_wr_ptr    <= '0;
            frame_cnt     <= '0;
            drop_cnt      <= '0;
        end else begin
            len_push_pend <= commit;
            if (len_push_pend) len_wr_ptr <= len_wr_ptr + LP_W'(1);
            if (wr_en) begin
                wr_ptr   <= wr_ptr + DP_W'(1);
                byte_acc <= acc_next;
            end
            if (commit) begin
                commit_ptr   <= wr_ptr + DP_W'(1);
                len_push_val <= acc_next;
                frame_cnt    <= frame_cnt + 32'd1;
            end
            // Discard the partial frame by rewinding to the last commit point
            if (rollback) wr_ptr <= commit_ptr;
            if (drop_inc) drop_cnt <= drop_cnt + 32'd1;
        end
    end

    // Storage arrays (no reset)
    always_ff @(posedge user_clk) begin
        if (wr_en) begin
            data_mem[wr_ptr[DA_W-1:0]] <= '{data: rx_data, ben: rx_ben, last: rx_last};
        end
        if (len_push_pend) begin
            len_mem[len_wr_ptr[LA_W-1:0]] <= len_push_val;
        end
    end

    // Output FSM: state register
    always_ff @(posedge user_clk) begin
        if (user_reset) out_state <= OUT_IDLE;
        else            out_state <= out_next;
    end

    // Output FSM: next state and read strobes
    always_comb begin
        out_next   = out_state;
        len_pop    = 1'b0;
        out_load   = 1'b0;
        out_reload = 1'b0;
        beat_adv   = 1'b0;
        case (out_state)
            OUT_IDLE: begin
                if (!len_empty) begin
                    len_pop  = 1'b1;
                    out_next = OUT_LOAD;
                end
            end
            OUT_LOAD: begin
                out_load = 1'b1;
                out_next = OUT_SEND;
            end
            OUT_SEND: begin
                if (m_tready) begin
                    beat_adv = 1'b1;
                    if (m_tlast) out_next   = OUT_IDLE;
                    else         out_reload = 1'b1;
                end
            end
            default: out_next = OUT_IDLE;
        endcase
    end

    // rd_ptr tracks the beat held in the output register; on a handshake the
    // following beat is read directly so the register reloads without a bubble.
    always_comb begin
        rd_addr  = out_load ? rd_ptr[DA_W-1:0] : rd_ptr[DA_W-1:0] + DA_W'(1);
        rd_entry = data_mem[rd_addr];
    end

    // Read side pointers and registered stream outputs
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            rd_ptr     <= '0;
            len_rd_ptr <= '0;
            m_tvalid   <= 1'b0;
            m_tdata    <= '0;
            m_tkeep    <= '0;
            m_tlast    <= 1'b0;
            m_len      <= '0;
        end else begin
            m_tvalid <= (out_next == OUT_SEND);
            if (len_pop) begin
                m_len      <= len_mem[len_rd_ptr[LA_W-1:0]];
                len_rd_ptr <= len_rd_ptr + LP_W'(1);
            end
            if (beat_adv) rd_ptr <= rd_ptr + DP_W'(1);
            if (out_load || out_reload) begin
                m_tdata <= rd_entry.data;
                m_tkeep <= rd_entry.ben;
                m_tlast <= rd_entry.last;
            end
        end
    end

endmodule

// File: doc/c2h_frame_buffer.md
# c2h_frame_buffer

Store-and-forward frame buffer placed directly downstream of the synthetic Ethernet traffic generator, in front of the QDMA C2H streaming interface. The generator's RX stream has no backpressure, so this block absorbs complete frames, drops any frame that cannot fit, and replays committed frames on an AXI4-Stream-style master port with full `tready` backpressure. It also provides the per-frame byte length that C2H needs, plus accept and drop counters.

## Interface
- `DATA_WIDTH`, 128: data bus width in bits, same on both sides.
- `KEEP_WIDTH`, DATA_WIDTH/8: byte-enable width.
- `DATA_DEPTH`, 256: data FIFO depth in beats; power of two, ≥ 4.
- `LEN_DEPTH`, 32: length FIFO depth in frames; power of two, ≥ 2.
- `LEN_WIDTH`, 16: frame byte-count width.
- `user_clk` in 1: the block's only clock.
- `user_reset` in 1: synchronous, active-high reset.
- `rx_valid` in 1: input beat valid. There is no ready; every valid beat is consumed.
- `rx_data` in DATA_WIDTH: input beat. Byte j is `[j*8 +: 8]`.
- `rx_ben` in KEEP_WIDTH: byte enables, contiguous from bit 0.
- `rx_last` in 1: last beat of frame; qualified by `rx_valid`.
- `m_tvalid` out 1: output beat valid.
- `m_tready` in 1: downstream ready.
- `m_tdata` out DATA_WIDTH: output data.
- `m_tkeep` out KEEP_WIDTH: copy of the stored `rx_ben`.
- `m_tlast` out 1: last beat of frame.
- `m_len` out LEN_WIDTH: byte length of the current frame; stable across all beats of that frame.
- `frame_cnt` out 32: frames committed since reset; wraps.
- `drop_cnt` out 32: frames dropped since reset; wraps.

## Operation
- **Storage.**
  - Data FIFO entries are {data, ben, last}.
  - Length FIFO entries are LEN_WIDTH byte counts.
  - The data FIFO has two write pointers: `wr_ptr` (speculative) and `commit_ptr`.
  - The read side sees only entries up to `commit_ptr`.
  - Pointers are log2(DEPTH)+1 bits. Full/empty use the MSB-differ rule.
- **Input FSM.** States are IN_IDLE, IN_ACCEPT and IN_DROP.
- **IN_IDLE**, on `rx_valid`:
  - If the length FIFO is full or the data FIFO is full: go to IN_DROP, or stay in IN_IDLE and increment `drop_cnt` if `rx_last`.
  - Otherwise: write the beat, set `byte_acc` = popcount(`rx_ben`), and go to IN_ACCEPT. If `rx_last` is also set, commit immediately and stay in IN_IDLE.
- **IN_ACCEPT**, on `rx_valid`:
  - If the data FIFO is full: set `wr_ptr` ← `commit_ptr`, go to IN_DROP, or to IN_IDLE with `drop_cnt`+1 if `rx_last`.
  - Otherwise: write the beat and add popcount(`rx_ben`) to `byte_acc`.
  - On `rx_last`, commit: `commit_ptr` ← `wr_ptr`+1, push `byte_acc` (including this beat) to the length FIFO, `frame_cnt`+1, go to IN_IDLE.
- **IN_DROP:** discard beats. On `rx_valid & rx_last`, increment `drop_cnt` and go to IN_IDLE.
- **Length FIFO fullness** is checked only at frame start. A frame admitted at start always has a length slot, because only the input side pushes.
- **Byte count.** `byte_acc` saturates at 2^LEN_WIDTH−1.
- **Output FSM.** States are OUT_IDLE, OUT_LOAD and OUT_SEND.
  - OUT_IDLE: if the length FIFO is not empty, pop into the `m_len` register and go to OUT_LOAD.
  - OUT_LOAD: issue the data-RAM read for the head beat. The output register is filled next cycle, then go to OUT_SEND.
  - OUT_SEND: `m_tvalid`=1. On `m_tvalid & m_tready`, advance the read pointer. The output register must reload without a bubble, so use prefetch or a one-entry skid.
  - When the beat with `m_tlast`=1 transfers, go to OUT_IDLE. `m_len` is held until then.
- **Back-to-back frames.** Up to 2 idle cycles between frames are acceptable.
- **AXI rules.**
  - Once `m_tvalid` is high, `m_tdata`, `m_tkeep`, `m_tlast` and `m_len` hold until handshake.
  - `m_tvalid` never drops without a handshake.
- **Simultaneous events.**
  - A write and a read in the same cycle are both performed.
  - A commit and a length pop in the same cycle are both performed.
  - Fullness uses the pre-edge pointers, so a beat arriving while full is dropped even if a read frees a slot on the same edge.
- **Reset.** Reset mid-operation aborts everything. Partial and committed-but-unsent frames are lost, and the input FSM returns to IN_IDLE, so the next `rx_valid` beat is treated as a frame start.

## Timing
- **Reset values:**
  - `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `m_tkeep`=0, `m_len`=0.
  - `frame_cnt`=0, `drop_cnt`=0.
  - All pointers 0; FSMs in IN_IDLE / OUT_IDLE.
- **Latency.** With the output idle, a `rx_last` beat sampled at edge N produces `m_tvalid`=1 with the first beat in the cycle after edge N+3:
  - N+1: commit visible.
  - N+2: length pop (OUT_IDLE → OUT_LOAD).
  - N+3: RAM read, output register filled.
- **Throughput.** Under continuous `m_tready`=1, one beat per cycle within a frame.
- **Counters.** `frame_cnt` and `drop_cnt` update at the edge that samples the last input beat.

## Test plan
- **Single frame.** One 1518-byte frame: 95 beats, the first 94 with ben=16'hFFFF and the last with 16'h3FFF, `m_tready`=1.
  - Expect 95 output beats with identical data.
  - Expect `m_tkeep`=16'h3FFF only on the `m_tlast` beat.
  - Expect `m_len`=1518, `frame_cnt`=1, first `m_tvalid` 3 cycles after the last input edge.
- **Overflow drop.** `m_tready`=0, three back-to-back 1518-byte frames, DATA_DEPTH=256.
  - Frames 1–2 commit (190 beats); frame 3 hits full at its 67th beat and is dropped.
  - Expect `frame_cnt`=2, `drop_cnt`=1.
  - Release `m_tready`: exactly 2 frames out, each `m_len`=1518.
- **Length-FIFO full.** LEN_DEPTH=2, `m_tready`=0, three 1-beat frames with ben=16'h000F.
  - Expect the third dropped, `drop_cnt`=1, and 2 output frames with `m_len`=4.
- **Random backpressure.** `m_tready` random 50% over 20 frames.
  - Data, keep and last match the input order.
  - Outputs stay stable while `m_tvalid & !m_tready`.
  - No beat is lost or duplicated.
- **Reset mid-frame.** Assert `user_reset` for 1 cycle at beat 40 of a frame, then send one 64-byte frame (4 beats).
  - Expect all outputs and counters 0 after reset, then exactly one output frame with `m_len`=64 and `frame_cnt`=1.
- **Simultaneous read/write at full.**
  - Fill to DATA_DEPTH−1, then present an input beat on the same edge as an output handshake.
  - Expect the beat accepted, pointers consistent, and no spurious drop.
